// File: rtl/noc_pkg.sv
// Shared constants and routing helper for the 5-port XY mesh router tile.
package noc_pkg;

  localparam int NPORTS = 5;
  localparam int P_N    = 0;
  localparam int P_E    = 1;
  localparam int P_S    = 2;
  localparam int P_W    = 3;
  localparam int P_L    = 4;

  // Destination coordinates sit in the low byte of ctrl; upper ctrl bits are opaque.
  localparam int DX_LSB  = 0;
  localparam int DY_LSB  = 4;
  localparam int COORD_W = 4;

  // Dimension-order route: resolve x first, then y. North is decreasing y.
  function automatic logic [2:0] xy_route(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy,
                                          input logic [COORD_W-1:0] tx,
                                          input logic [COORD_W-1:0] ty);
    if (dx > tx)      return 3'(P_E);
    else if (dx < tx) return 3'(P_W);
    else if (dy > ty) return 3'(P_S);
    else if (dy < ty) return 3'(P_N);
    else              return 3'(P_L);
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Per-input synchronous FIFO. The caller only pushes when not full and only pops when not empty.
module noc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;

  // Storage needs no reset: count gates every read of stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rp];
  assign empty = (count == '0);

endmodule

// File: rtl/noc_router_tile.sv
// 5-port XY mesh router tile: input FIFOs, per-output round-robin arbitration, registered outputs.
module noc_router_tile import noc_pkg::*; #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 16,   // must be >= 8 (dest_x/dest_y in the low byte)
  parameter int TILE_X     = 0,
  parameter int TILE_Y     = 0,
  parameter int MESH_X     = 3,
  parameter int MESH_Y     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NPORTS*(2*DATA_W+CTRL_W)-1:0]       in_flit,
  input  logic [NPORTS-1:0]                         in_valid,
  output logic [NPORTS-1:0]                         in_ready,
  output logic [NPORTS*(2*DATA_W+CTRL_W)-1:0]       out_flit,
  output logic [NPORTS-1:0]                         out_valid,
  input  logic [NPORTS-1:0]                         out_ready,
  output logic [15:0]                               drop_count
);
  localparam int FLIT_W = 2*DATA_W + CTRL_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COORD_W:0]   MX = (COORD_W+1)'(MESH_X);
  localparam logic [COORD_W:0]   MY = (COORD_W+1)'(MESH_Y);
  localparam logic [COORD_W-1:0] TX = COORD_W'(TILE_X);
  localparam logic [COORD_W-1:0] TY = COORD_W'(TILE_Y);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } flit_t;

  flit_t [NPORTS-1:0]                  head;
  logic  [NPORTS-1:0][CNT_W-1:0]       cnt;
  logic  [NPORTS-1:0]                  full, empty, push, pop, illegal;
  logic  [NPORTS-1:0][NPORTS-1:0]      req;   // [output][input]
  logic  [NPORTS-1:0][NPORTS-1:0]      gnt;   // [output][input]
  logic  [16:0]                        drop_sum;

  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    // Ready comes from the registered count only, so a same-cycle pop never frees a full FIFO.
    assign full[p]     = (cnt[p] == CNT_W'(FIFO_DEPTH));
    assign in_ready[p] = !full[p];
    assign push[p]     = in_valid[p] && !full[p];

    noc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(FLIT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[p]),
      .din   (in_flit[p*FLIT_W +: FLIT_W]),
      .pop   (pop[p]),
      .dout  (head[p]),
      .empty (empty[p]),
      .count (cnt[p])
    );
  end

  // Classify each FIFO head: out-of-mesh heads are dropped, the rest request one output.
  always_comb begin
    illegal = '0;
    req     = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (!empty[p]) begin
        if ({1'b0, head[p].ctrl[DX_LSB +: COORD_W]} >= MX ||
            {1'b0, head[p].ctrl[DY_LSB +: COORD_W]} >= MY)
          illegal[p] = 1'b1;
        else
          req[xy_route(head[p].ctrl[DX_LSB +: COORD_W],
                       head[p].ctrl[DY_LSB +: COORD_W], TX, TY)][p] = 1'b1;
      end
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    logic [2:0] rr, gi;
    logic       v, gv, free;
    flit_t      f;

    assign free = !v || out_ready[o];

    // Round-robin search starting at rr.
    always_comb begin
      gv = 1'b0;
      gi = '0;
      for (int k = 0; k < NPORTS; k++) begin
        if (!gv && req[o][(int'(rr) + k) % NPORTS]) begin
          gv = 1'b1;
          gi = 3'((int'(rr) + k) % NPORTS);
        end
      end
    end

    assign gnt[o] = (free && gv) ? (NPORTS'(1) << gi) : '0;

    // Output register: load on grant, clear once consumed, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rr <= '0;
        v  <= 1'b0;
        f  <= '0;
      end else if (free) begin
        v <= gv;
        if (gv) begin
          f  <= head[gi];
          rr <= (gi == 3'(NPORTS-1)) ? '0 : gi + 3'd1;
        end
      end
    end

    assign out_valid[o]                   = v;
    assign out_flit[o*FLIT_W +: FLIT_W]   = f;
  end

  // A head pops when granted by any output or when it is being dropped.
  always_comb begin
    pop = illegal;
    for (int o = 0; o < NPORTS; o++) pop = pop | gnt[o];
  end

  // Several ports may drop in one cycle; the 17th bit catches overflow for saturation.
  always_comb begin
    drop_sum = {1'b0, drop_count} + 17'($countones(illegal));
  end

  // Saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              drop_count <= '0;
    else if (drop_sum[16]) drop_count <= 16'hFFFF;
    else                  drop_count <= drop_sum[15:0];
  end

endmodule

// File: tb/tb_noc_router_tile.sv
// Bench for noc_router_tile at TILE=(1,1) in a 3x3 mesh: queue-level model plus directed literal checks.
module tb_noc_router_tile;
  localparam int DW = 16, CW = 16, FW = 2*DW + CW, D = 4, NP = 5;
  localparam int N = 0, E = 1, S = 2, W = 3, L = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*FW-1:0]  in_flit, out_flit;
  logic [NP-1:0]     in_valid, in_ready, out_valid, out_ready;
  logic [15:0]       drop_count;

  int passes = 0, checks = 0;
  logic chk_en = 1'b0;

  // Model state: input queues, output slots, round-robin pointers, drop counter.
  logic [FW-1:0] mq [NP][$];
  logic [NP-1:0] mv;
  logic [FW-1:0] mf [NP];
  int            mrr [NP];
  int            mdrop;

  always #5 clk = ~clk;

  noc_router_tile #(.DATA_W(DW), .CTRL_W(CW), .TILE_X(1), .TILE_Y(1),
                    .MESH_X(3), .MESH_Y(3), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready), .drop_count(drop_count));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [FW-1:0] mk(input int dx, input int dy, input int a, input int b);
    logic [3:0] x, y;
    x = 4'(dx); y = 4'(dy);
    return {8'hC3, y, x, 16'(a), 16'(b)};
  endfunction

  // Destination port for a flit at tile (1,1) of a 3x3 mesh; -1 means drop.
  function automatic int route(input logic [FW-1:0] f);
    int dx, dy;
    dx = int'(f[32 +: 4]); dy = int'(f[36 +: 4]);
    if (dx >= 3 || dy >= 3) return -1;
    if (dx > 1) return E;
    if (dx < 1) return W;
    if (dy > 1) return S;
    if (dy < 1) return N;
    return L;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin mq[p].delete(); mf[p] = '0; mrr[p] = 0; end
    mv = '0; mdrop = 0;
  endtask

  // One clock edge of the router, expressed on queues.
  task automatic model_step();
    logic [NP-1:0] acc, pp;
    pp = '0;
    for (int p = 0; p < NP; p++) acc[p] = in_valid[p] && (mq[p].size() < D);
    for (int p = 0; p < NP; p++)
      if (mq[p].size() > 0 && route(mq[p][0]) < 0) begin
        pp[p] = 1'b1;
        if (mdrop < 65535) mdrop++;
      end
    for (int o = 0; o < NP; o++) begin
      if (!mv[o] || out_ready[o]) begin
        int g; g = -1;
        for (int k = 0; k < NP; k++) begin
          int i; i = (mrr[o] + k) % NP;
          if (g < 0 && mq[i].size() > 0 && route(mq[i][0]) == o) g = i;
        end
        if (g >= 0) begin
          mv[o] = 1'b1; mf[o] = mq[g][0]; pp[g] = 1'b1; mrr[o] = (g + 1) % NP;
        end else mv[o] = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (pp[p]) void'(mq[p].pop_front());
      if (acc[p]) mq[p].push_back(in_flit[p*FW +: FW]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
  endtask

  task automatic drive(input int p, input logic [FW-1:0] f);
    in_valid[p] = 1'b1;
    in_flit[p*FW +: FW] = f;
  endtask

  function automatic logic [FW-1:0] oslice(input int p);
    return out_flit[p*FW +: FW];
  endfunction

  // Compare DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin : cmp
    logic [NP-1:0] rdy;
    if (chk_en && !rst) begin
      for (int p = 0; p < NP; p++) rdy[p] = (mq[p].size() < D);
      check("in_ready", 64'(in_ready), 64'(rdy));
      check("out_valid", 64'(out_valid), 64'(mv));
      for (int p = 0; p < NP; p++)
        if (mv[p]) check("out_flit", 64'(oslice(p)), 64'(mf[p]));
      check("drop_count", 64'(drop_count), 64'(mdrop));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] got [$];
    logic [FW-1:0] t;
    rst = 1'b1; in_valid = '0; in_flit = '0; out_ready = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'h1F);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_flit", 64'(|out_flit), 64'h0);
    check("rst_drop", 64'(drop_count), 64'h0);

    // Round-robin: N, S, L all target E for 5 cycles, then drain.
    for (int c = 0; c < 25; c++) begin
      if (c < 5) begin drive(N, mk(2, 1, N, c)); drive(S, mk(2, 1, S, c)); drive(L, mk(2, 1, L, c)); end
      else in_valid = '0;
      cycle();
      @(negedge clk);
      if (out_valid[E]) begin t = oslice(E); got.push_back(t[31:16]); end
    end
    check("rr_total", 64'(got.size()), 64'd15);
    for (int i = 0; i < 6; i++) check("rr_order", 64'(got[i]), 64'((i % 3 == 0) ? N : (i % 3 == 1) ? S : L));
    got.delete();

    // W -> E, one-cycle latency, payload and ctrl preserved.
    drive(W, mk(2, 1, 5, 7)); cycle(); in_valid = '0; cycle();
    @(negedge clk);
    check("we_valid", 64'(out_valid[E]), 64'h1);
    check("we_flit", 64'(oslice(E)), 64'hC312_0005_0007);

    // N -> L (dest 1,1) and S -> N (dest 1,0).
    cycle();
    drive(N, mk(1, 1, 'h11, 'h22)); drive(S, mk(1, 0, 'h33, 'h44)); cycle(); in_valid = '0; cycle();
    @(negedge clk);
    check("nl_valid", 64'(out_valid), 64'b10001);
    check("nl_flitL", 64'(oslice(L)), 64'hC311_0011_0022);
    check("sn_flitN", 64'(oslice(N)), 64'hC301_0033_0044);

    // Backpressure: E stalled, 5 flits from W fill output reg + FIFO.
    cycle();
    out_ready[E] = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(W, mk(2, 1, i, 'h100 + i)); cycle(); end
    in_valid = '0;
    @(negedge clk);
    check("bp_ready_w", 64'(in_ready[W]), 64'h0);
    check("bp_head", 64'(oslice(E)), 64'hC312_0000_0100);
    cycle();
    out_ready[E] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid[E]) begin t = oslice(E); got.push_back(t[31:16]); end
      cycle();
    end
    check("bp_total", 64'(got.size()), 64'd5);
    for (int i = 0; i < 5; i++) check("bp_order", 64'(got[i]), 64'(i));

    // Out-of-mesh destination (3,0) dropped; next legal flit on L still goes out W.
    drive(L, mk(3, 0, 'h55, 'h66)); cycle(); in_valid = '0; cycle();
    @(negedge clk);
    check("drop_cnt", 64'(drop_count), 64'h1);
    check("drop_noout", 64'(out_valid), 64'h0);
    cycle();
    drive(L, mk(0, 1, 'h77, 'h88)); cycle(); in_valid = '0; cycle();
    @(negedge clk);
    check("after_drop_v", 64'(out_valid), 64'b01000);
    check("after_drop_f", 64'(oslice(W)), 64'hC310_0077_0088);
    cycle();

    // Reset with flits buffered: nothing stale may come out afterwards.
    out_ready[E] = 1'b0;
    for (int i = 0; i < 4; i++) begin drive(W, mk(2, 1, 'h90 + i, 0)); cycle(); end
    in_valid = '0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid", 64'(out_valid), 64'h0);
    check("arst_drop", 64'(drop_count), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 64'(in_ready), 64'h1F);
    out_ready = '1;
    repeat (6) cycle();
    @(negedge clk);
    check("no_stale", 64'(out_valid), 64'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
